// File: rtl/store_buffer.sv
// store_buffer
//   In-order write buffer between the processor and data memory. Accepted
//   stores queue up in a DEPTH-entry FIFO and drain one at a time through a
//   request/ack handshake. Loads can look up the buffer and forward the data
//   of the youngest pending store to the same address.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   cpu_we     processor store request
//   cpu_adr    store address (full 32-bit compare)
//   cpu_wdata  store data
//   cpu_stall  buffer full, a store this cycle is dropped
//   ld_adr     load lookup address
//   ld_hit     some valid entry matches ld_adr
//   ld_data    data of the youngest matching entry, 0 on miss
//   mem_we     head entry valid, write request to memory
//   mem_adr    head entry address, 0 when empty
//   mem_wdata  head entry data, 0 when empty
//   mem_ack    memory accepts the head entry this cycle
//   count      number of valid entries
//   empty      count == 0
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_adr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_stall,
  input  logic [31:0]              ld_adr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     mem_we,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]    adr_r  [DEPTH];
  logic [31:0]    data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0]  head_r;
  logic [AW-1:0]  tail_r;
  logic [CW-1:0]  count_r;

  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic           hit_s;
  logic [31:0]    hit_data_s;
  logic [AW-1:0]  idx_s;

  // Status and handshake qualifiers derived from registered state only.
  always_comb begin
    full_s  = (count_r == CW'(DEPTH));
    empty_s = (count_r == {CW{1'b0}});
    // A full buffer never accepts, even if the head drains this same cycle.
    push_s  = cpu_we & ~full_s;
    // mem_ack is meaningless while nothing is requested.
    pop_s   = mem_ack & ~empty_s;
  end

  // FIFO storage, pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        adr_r[i]  <= 32'd0;
        data_r[i] <= 32'd0;
      end
    end else begin
      // push and pop never touch the same slot: push needs count<DEPTH and
      // pop needs count>0, so head==tail cannot hold for both at once.
      if (push_s) begin
        adr_r[tail_r]   <= cpu_adr;
        data_r[tail_r]  <= cpu_wdata;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + AW'(1);
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Load forwarding: walk from head (oldest) toward tail so the youngest
  // match overwrites older ones. Entries popping this cycle are still valid.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 32'd0;
    idx_s      = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + AW'(i);
      if (valid_r[idx_s] && (adr_r[idx_s] == ld_adr)) begin
        hit_s      = 1'b1;
        hit_data_s = data_r[idx_s];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Memory-side request presents the head entry, zeroed when empty.
  always_comb begin
    if (empty_s) begin
      mem_adr   = 32'd0;
      mem_wdata = 32'd0;
    end else begin
      mem_adr   = adr_r[head_r];
      mem_wdata = data_r[head_r];
    end
  end

  assign mem_we    = ~empty_s;
  assign cpu_stall = full_s;
  assign count     = count_r;
  assign empty     = empty_s;
  assign ld_hit    = hit_s;
  assign ld_data   = hit_data_s;

endmodule
